// File: rtl/recovery_request_collector_pkg.sv
// rtl/recovery_request_collector_pkg.sv - shared recovery-manager types: request payload and collector state
package RecoveryManagerTypes;

  localparam int ACTIVE_LIST_INDEX_WIDTH     = 6;
  localparam int PC_WIDTH                    = 32;
  localparam int BRANCH_GLOBAL_HISTORY_WIDTH = 10;

  typedef logic [2:0]                             RefetchType;
  typedef logic [ACTIVE_LIST_INDEX_WIDTH-1:0]     ActiveListIndexPath;
  typedef logic [PC_WIDTH-1:0]                    PC_Path;
  typedef logic [BRANCH_GLOBAL_HISTORY_WIDTH-1:0] BranchGlobalHistoryPath;

  typedef enum logic [1:0] {
    RECOVERY_REQ_IDLE,
    RECOVERY_REQ_PENDING,
    RECOVERY_REQ_RECOVERING
  } RecoveryReqState;

  typedef struct packed {
    ActiveListIndexPath     alPtr;
    RefetchType             refetchType;
    PC_Path                 pc;
    BranchGlobalHistoryPath brHistory;
  } RecoveryRequest;

endpackage

// File: rtl/recovery_request_collector_age.sv
// rtl/recovery_request_collector_age.sv - combinational oldest-lane pick by ActiveList age relative to head
module recovery_age_selector #(
  parameter int NUM_LANES = 2,
  parameter int AL_IDX_W  = 6,
  parameter int SEL_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0]          valid,
  input  logic [NUM_LANES*AL_IDX_W-1:0] alPtr,
  input  logic [AL_IDX_W-1:0]           headPtr,
  output logic                          anyValid,
  output logic [SEL_W-1:0]              selLane,
  output logic [AL_IDX_W-1:0]           selAge
);

  logic [AL_IDX_W-1:0] age;

  // Strict less-than keeps the lower lane index on equal ages.
  always_comb begin
    anyValid = 1'b0;
    selLane  = '0;
    selAge   = '0;
    age      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      age = alPtr[i*AL_IDX_W +: AL_IDX_W] - headPtr;
      if (valid[i] && (!anyValid || age < selAge)) begin
        anyValid = 1'b1;
        selLane  = SEL_W'(i);
        selAge   = age;
      end
    end
  end

endmodule

// File: rtl/recovery_request_collector.sv
// rtl/recovery_request_collector.sv - holds the oldest RW-stage recovery request until the recovery manager accepts it
// Optional replacement statistics counter enabled by RSD_RECOVERY_REQ_STATS_EN.
module recovery_request_collector
  import RecoveryManagerTypes::*;
#(
  parameter int NUM_LANES = 2,
  parameter int AL_IDX_W  = ACTIVE_LIST_INDEX_WIDTH,
  parameter int ADDR_W    = PC_WIDTH,
  parameter int GHIST_W   = BRANCH_GLOBAL_HISTORY_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES-1:0]          reqValid,
  input  logic [NUM_LANES*AL_IDX_W-1:0] reqAlPtr,
  input  logic [NUM_LANES*3-1:0]        reqRefetchType,
  input  logic [NUM_LANES*ADDR_W-1:0]   reqPC,
  input  logic [NUM_LANES*GHIST_W-1:0]  reqBrHistory,
  input  logic [AL_IDX_W-1:0]           alHeadPtr,
  input  logic                          toRecoveryPhase,
  input  logic                          toCommitPhase,
  input  logic                          unableToStartRecovery,
  output logic                          exceptionDetectedInRwStage,
  output logic [2:0]                    refetchTypeFromRwStage,
  output logic [ADDR_W-1:0]             recoveredPC_FromRwStage,
  output logic [GHIST_W-1:0]            recoveredBrHistoryFromRwStage,
  output logic [AL_IDX_W-1:0]           recoveryAlPtr,
  output logic [15:0]                   replacedCount
);

  localparam int SEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  RecoveryReqState     state;
  RecoveryRequest      held;
  RecoveryRequest      selReq;
  logic                anyValid;
  logic [SEL_W-1:0]    selLane;
  logic [AL_IDX_W-1:0] selAge;
  logic [AL_IDX_W-1:0] heldAge;
  logic                doReplace;
  int                  selIdx;

  recovery_age_selector #(
    .NUM_LANES (NUM_LANES),
    .AL_IDX_W  (AL_IDX_W),
    .SEL_W     (SEL_W)
  ) ageSelector (
    .valid    (reqValid),
    .alPtr    (reqAlPtr),
    .headPtr  (alHeadPtr),
    .anyValid (anyValid),
    .selLane  (selLane),
    .selAge   (selAge)
  );

  always_comb begin
    selReq             = '0;
    selIdx             = int'(selLane);
    selReq.alPtr       = reqAlPtr[selIdx*AL_IDX_W +: AL_IDX_W];
    selReq.refetchType = reqRefetchType[selIdx*3 +: 3];
    selReq.pc          = reqPC[selIdx*ADDR_W +: ADDR_W];
    selReq.brHistory   = reqBrHistory[selIdx*GHIST_W +: GHIST_W];
  end

  // Held age is re-evaluated against the live head so retirement never skews the comparison.
  assign heldAge   = held.alPtr - alHeadPtr;
  assign doReplace = (state == RECOVERY_REQ_PENDING) && !toRecoveryPhase &&
                     !unableToStartRecovery && anyValid && (selAge < heldAge);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RECOVERY_REQ_IDLE;
      held  <= '0;
    end else if (toRecoveryPhase) begin
      state <= RECOVERY_REQ_RECOVERING;
      held  <= '0;
    end else begin
      case (state)
        RECOVERY_REQ_IDLE: begin
          if (anyValid) begin
            held  <= selReq;
            state <= RECOVERY_REQ_PENDING;
          end
        end
        RECOVERY_REQ_PENDING: begin
          if (doReplace) held <= selReq;
        end
        RECOVERY_REQ_RECOVERING: begin
          if (toCommitPhase) state <= RECOVERY_REQ_IDLE;
        end
        default: begin
          state <= RECOVERY_REQ_IDLE;
          held  <= '0;
        end
      endcase
    end
  end

  // held is only loaded on entry to PENDING and cleared on every exit, so it is zero elsewhere.
  assign exceptionDetectedInRwStage    = (state == RECOVERY_REQ_PENDING);
  assign refetchTypeFromRwStage        = held.refetchType;
  assign recoveredPC_FromRwStage       = held.pc;
  assign recoveredBrHistoryFromRwStage = held.brHistory;
  assign recoveryAlPtr                 = held.alPtr;

`ifdef RSD_RECOVERY_REQ_STATS_EN
  logic [15:0] replCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      replCnt <= '0;
    end else if (doReplace && replCnt != 16'hFFFF) begin
      replCnt <= replCnt + 16'd1;
    end
  end

  assign replacedCount = replCnt;
`else
  assign replacedCount = '0;
`endif

endmodule

// File: tb/tb_recovery_request_collector.sv
// tb/tb_recovery_request_collector.sv - directed self-checking bench for recovery_request_collector
module tb_recovery_request_collector;

`ifdef RSD_RECOVERY_REQ_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  reqValid;
  logic [11:0] reqAlPtr;
  logic [5:0]  reqRefetchType;
  logic [63:0] reqPC;
  logic [19:0] reqBrHistory;
  logic [5:0]  alHeadPtr;
  logic        toRecoveryPhase, toCommitPhase, unableToStartRecovery;
  logic        exceptionDetectedInRwStage;
  logic [2:0]  refetchTypeFromRwStage;
  logic [31:0] recoveredPC_FromRwStage;
  logic [9:0]  recoveredBrHistoryFromRwStage;
  logic [5:0]  recoveryAlPtr;
  logic [15:0] replacedCount;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  recovery_request_collector dut (
    .clk                           (clk),
    .rst                           (rst),
    .reqValid                      (reqValid),
    .reqAlPtr                      (reqAlPtr),
    .reqRefetchType                (reqRefetchType),
    .reqPC                         (reqPC),
    .reqBrHistory                  (reqBrHistory),
    .alHeadPtr                     (alHeadPtr),
    .toRecoveryPhase               (toRecoveryPhase),
    .toCommitPhase                 (toCommitPhase),
    .unableToStartRecovery         (unableToStartRecovery),
    .exceptionDetectedInRwStage    (exceptionDetectedInRwStage),
    .refetchTypeFromRwStage        (refetchTypeFromRwStage),
    .recoveredPC_FromRwStage       (recoveredPC_FromRwStage),
    .recoveredBrHistoryFromRwStage (recoveredBrHistoryFromRwStage),
    .recoveryAlPtr                 (recoveryAlPtr),
    .replacedCount                 (replacedCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setLane(input int lane, input logic v, input logic [5:0] ptr,
                         input logic [2:0] rt, input logic [31:0] pc, input logic [9:0] hist);
    reqValid[lane]             = v;
    reqAlPtr[lane*6 +: 6]      = ptr;
    reqRefetchType[lane*3 +: 3] = rt;
    reqPC[lane*32 +: 32]       = pc;
    reqBrHistory[lane*10 +: 10] = hist;
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_exc"},  32'(exceptionDetectedInRwStage), 32'd0);
    check({tag, "_ptr"},  32'(recoveryAlPtr), 32'd0);
    check({tag, "_pc"},   recoveredPC_FromRwStage, 32'd0);
    check({tag, "_rt"},   32'(refetchTypeFromRwStage), 32'd0);
    check({tag, "_hist"}, 32'(recoveredBrHistoryFromRwStage), 32'd0);
  endtask

  initial begin
    rst = 1'b1; reqValid = '0; reqAlPtr = '0; reqRefetchType = '0; reqPC = '0;
    reqBrHistory = '0; alHeadPtr = '0; toRecoveryPhase = 0; toCommitPhase = 0;
    unableToStartRecovery = 0;
    step(); step();
    checkIdleOutputs("reset");
    check("reset_cnt", 32'(replacedCount), 32'd0);

    // Single-lane capture, visible the cycle after the request.
    rst = 1'b0;
    setLane(0, 1, 6'd5, 3'd3, 32'h1000, 10'h155);
    step();
    check("cap_exc",  32'(exceptionDetectedInRwStage), 32'd1);
    check("cap_pc",   recoveredPC_FromRwStage, 32'h1000);
    check("cap_ptr",  32'(recoveryAlPtr), 32'd5);
    check("cap_rt",   32'(refetchTypeFromRwStage), 32'd3);
    check("cap_hist", 32'(recoveredBrHistoryFromRwStage), 32'h155);
    setLane(0, 0, 0, 0, 0, 0);
    toRecoveryPhase = 1; step(); toRecoveryPhase = 0;
    checkIdleOutputs("flush1");
    toCommitPhase = 1; step(); toCommitPhase = 0;

    // Two lanes same cycle: head=2, ptr9 age7 vs ptr4 age2 -> lane1.
    alHeadPtr = 6'd2;
    setLane(0, 1, 6'd9, 3'd1, 32'h2000, 10'h011);
    setLane(1, 1, 6'd4, 3'd2, 32'h3000, 10'h022);
    step();
    check("sel_ptr", 32'(recoveryAlPtr), 32'd4);
    check("sel_pc",  recoveredPC_FromRwStage, 32'h3000);
    check("sel_cnt", 32'(replacedCount), 32'd0);
    setLane(1, 0, 0, 0, 0, 0);
    setLane(0, 1, 6'd3, 3'd4, 32'h4000, 10'h033);
    step();
    check("repl_ptr", 32'(recoveryAlPtr), 32'd3);
    check("repl_pc",  recoveredPC_FromRwStage, 32'h4000);
    check("repl_cnt", 32'(replacedCount), 32'(STATS));
    // Equal age does not replace.
    setLane(0, 0, 0, 0, 0, 0);
    setLane(1, 1, 6'd3, 3'd5, 32'h5000, 10'h044);
    step();
    check("tie_pc",  recoveredPC_FromRwStage, 32'h4000);
    check("tie_cnt", 32'(replacedCount), 32'(STATS));
    setLane(1, 0, 0, 0, 0, 0);
    toRecoveryPhase = 1; step(); toRecoveryPhase = 0;
    toCommitPhase = 1; step(); toCommitPhase = 0;

    // Wrap-around: head=60, held ptr62 (age2); ptr1 has age5 -> kept.
    alHeadPtr = 6'd60;
    setLane(0, 1, 6'd62, 3'd1, 32'h6000, 10'h066);
    step();
    check("wrap_cap", 32'(recoveryAlPtr), 32'd62);
    setLane(0, 1, 6'd1, 3'd2, 32'h7000, 10'h077);
    step();
    check("wrap_keep_ptr", 32'(recoveryAlPtr), 32'd62);
    check("wrap_keep_pc",  recoveredPC_FromRwStage, 32'h6000);
    check("wrap_keep_cnt", 32'(replacedCount), 32'(STATS));
    setLane(0, 1, 6'd61, 3'd6, 32'h6100, 10'h061);
    step();
    check("wrap_repl_ptr", 32'(recoveryAlPtr), 32'd61);
    check("wrap_repl_cnt", 32'(replacedCount), 32'(2 * STATS));

    // Blocked start: older request (ptr60, age0) must not disturb the held one.
    unableToStartRecovery = 1;
    setLane(0, 0, 0, 0, 0, 0);
    setLane(1, 1, 6'd60, 3'd7, 32'hAAAA, 10'h3FF);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_exc", 32'(exceptionDetectedInRwStage), 32'd1);
      check("stall_pc",  recoveredPC_FromRwStage, 32'h6100);
      check("stall_ptr", 32'(recoveryAlPtr), 32'd61);
    end
    toRecoveryPhase = 1; step(); toRecoveryPhase = 0;
    unableToStartRecovery = 0;
    checkIdleOutputs("accept");
    step(); step();
    checkIdleOutputs("recov_ignore");
    toCommitPhase = 1; step(); toCommitPhase = 0;
    checkIdleOutputs("commit_edge");
    setLane(1, 0, 0, 0, 0, 0);
    alHeadPtr = 6'd0;
    setLane(0, 1, 6'd10, 3'd2, 32'h8000, 10'h088);
    step();
    check("idle_again_exc", 32'(exceptionDetectedInRwStage), 32'd1);
    check("idle_again_ptr", 32'(recoveryAlPtr), 32'd10);

    // Reset in PENDING, then immediate recapture.
    setLane(0, 0, 0, 0, 0, 0);
    rst = 1; step(); rst = 0;
    checkIdleOutputs("rst_pend");
    check("rst_cnt", 32'(replacedCount), 32'd0);
    setLane(0, 1, 6'd7, 3'd1, 32'h9000, 10'h099);
    step();
    check("post_rst_exc", 32'(exceptionDetectedInRwStage), 32'd1);
    check("post_rst_ptr", 32'(recoveryAlPtr), 32'd7);
    check("post_rst_pc",  recoveredPC_FromRwStage, 32'h9000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
